// File: rtl/rtc_alarm_scheduler.sv
// rtc_alarm_scheduler: scans N_ALARMS alarm slots one per cycle against a time snapshot on each tick and raises per-slot pending flags plus one IRQ.
// Define RTC_ALARM_WILDCARD_EN to store a per-slot field care mask (mask bit 0 = ignore that field).
module rtc_alarm_scheduler #(
    parameter int N_ALARMS = 4,
    localparam int IDX_W = $clog2(N_ALARMS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tick_i,
    input  logic [5:0]          cur_sec_i,
    input  logic [5:0]          cur_min_i,
    input  logic [5:0]          cur_hour_i,
    input  logic [1:0]          cur_mode_i,
    input  logic [2:0]          cur_day_of_week_i,
    input  logic [4:0]          cur_day_of_month_i,
    input  logic [3:0]          cur_month_i,
    input  logic [11:0]         cur_year_i,
    input  logic                cfg_we_i,
    input  logic [IDX_W-1:0]    cfg_idx_i,
    input  logic                cfg_en_i,
    input  logic [43:0]         cfg_time_i,
    input  logic [7:0]          cfg_mask_i,
    input  logic                ack_i,
    input  logic [IDX_W-1:0]    ack_idx_i,
    output logic [N_ALARMS-1:0] pending_o,
    output logic                irq_o,
    output logic                busy_o,
    output logic                scan_ovf_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [43:0]         snap_q, snap_d;
    logic                rescan_q, rescan_d;
    logic                ovf_q, ovf_d;
    logic [N_ALARMS-1:0] pending_q, pending_d;
    logic [N_ALARMS-1:0] en_q, en_d;
    logic [43:0]         time_q [N_ALARMS];
    logic [43:0]         time_d [N_ALARMS];
    logic [43:0]         care;
    logic [43:0]         cur;
    logic                last;
    logic                match;

`ifdef RTC_ALARM_WILDCARD_EN
    logic [7:0] mask_q [N_ALARMS];
    logic [7:0] mask_d [N_ALARMS];
    logic [7:0] m;
    assign m = mask_q[idx_q];
    // Expand the per-field mask onto the packed time layout
    assign care = {{12{m[7]}}, {4{m[6]}}, {5{m[5]}}, {3{m[4]}},
                   {2{m[3]}}, {6{m[2]}}, {6{m[1]}}, {6{m[0]}}};
`else
    logic unused_mask;
    assign unused_mask = ^cfg_mask_i;
    assign care = '1;
`endif

    assign cur = {cur_year_i, cur_month_i, cur_day_of_month_i, cur_day_of_week_i,
                  cur_mode_i, cur_hour_i, cur_min_i, cur_sec_i};
    assign last  = idx_q == IDX_W'(N_ALARMS - 1);
    assign match = state_q == SCAN && en_q[idx_q] && ((time_q[idx_q] ^ snap_q) & care) == '0;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        rescan_d  = rescan_q;
        ovf_d     = ovf_q;
        pending_d = pending_q;
        en_d      = en_q;
        time_d    = time_q;
`ifdef RTC_ALARM_WILDCARD_EN
        mask_d    = mask_q;
`endif
        if (state_q == IDLE) begin
            if (tick_i) begin
                snap_d  = cur;
                idx_d   = '0;
                state_d = SCAN;
            end
        end else begin
            if (tick_i) begin
                rescan_d = 1'b1;
                ovf_d    = ovf_q | rescan_q;
            end
            idx_d = idx_q + 1'b1;
            // A tick landing on the final slot edge restarts the scan immediately
            if (last) begin
                idx_d    = '0;
                rescan_d = 1'b0;
                snap_d   = (rescan_q || tick_i) ? cur : snap_q;
                state_d  = (rescan_q || tick_i) ? SCAN : IDLE;
            end
        end
        for (int i = 0; i < N_ALARMS; i++) begin
            if (ack_i && ack_idx_i == IDX_W'(i))
                pending_d[i] = 1'b0;
            if (match && idx_q == IDX_W'(i))
                pending_d[i] = 1'b1;
            if (cfg_we_i && cfg_idx_i == IDX_W'(i)) begin
                en_d[i]   = cfg_en_i;
                time_d[i] = cfg_time_i;
`ifdef RTC_ALARM_WILDCARD_EN
                mask_d[i] = cfg_mask_i;
`endif
                if (!cfg_en_i)
                    pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            snap_q    <= '0;
            rescan_q  <= 1'b0;
            ovf_q     <= 1'b0;
            pending_q <= '0;
            en_q      <= '0;
            time_q    <= '{default: '0};
`ifdef RTC_ALARM_WILDCARD_EN
            mask_q    <= '{default: '1};
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            rescan_q  <= rescan_d;
            ovf_q     <= ovf_d;
            pending_q <= pending_d;
            en_q      <= en_d;
            time_q    <= time_d;
`ifdef RTC_ALARM_WILDCARD_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign pending_o  = pending_q;
    assign irq_o      = |pending_q;
    assign busy_o     = state_q == SCAN;
    assign scan_ovf_o = ovf_q;
endmodule

// File: tb/tb_rtc_alarm_scheduler.sv
// tb_rtc_alarm_scheduler: scoreboard bench; each scan pushes its expected pending/busy length, checked when busy_o falls.
module tb_rtc_alarm_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [5:0]  sec = '0, min = '0, hour = '0;
    logic [1:0]  mode = '0;
    logic [2:0]  dow = '0;
    logic [4:0]  dom = '0;
    logic [3:0]  mon = '0;
    logic [11:0] year = '0;
    logic        cfg_we = 1'b0, cfg_en = 1'b0, ack = 1'b0;
    logic [1:0]  cfg_idx = '0, ack_idx = '0;
    logic [43:0] cfg_time = '0;
    logic [7:0]  cfg_mask = '1;
    logic [3:0]  pend;
    logic        irq, busy, ovf;

    int          checks = 0;
    int          failures = 0;
    logic [3:0]  hist [16];
    logic [3:0]  pend_q [$];
    int          busy_q [$];

    rtc_alarm_scheduler #(.N_ALARMS(4)) dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick),
        .cur_sec_i(sec), .cur_min_i(min), .cur_hour_i(hour), .cur_mode_i(mode),
        .cur_day_of_week_i(dow), .cur_day_of_month_i(dom), .cur_month_i(mon), .cur_year_i(year),
        .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_en_i(cfg_en), .cfg_time_i(cfg_time),
        .cfg_mask_i(cfg_mask), .ack_i(ack), .ack_idx_i(ack_idx),
        .pending_o(pend), .irq_o(irq), .busy_o(busy), .scan_ovf_o(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [43:0] mk(int s, int m, int h, int md, int dw, int dm, int mo, int y);
        return {12'(y), 4'(mo), 5'(dm), 3'(dw), 2'(md), 6'(h), 6'(m), 6'(s)};
    endfunction

    task automatic write_cfg(input int idx, input logic en, input logic [43:0] t, input logic [7:0] m);
        cfg_idx = 2'(idx); cfg_en = en; cfg_time = t; cfg_mask = m; cfg_we = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic ack_slot(input int idx);
        ack_idx = 2'(idx); ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic scan(input logic [43:0] t, input logic [3:0] exp_pend, input int exp_busy,
                        input logic [7:0] tick_at, input logic [7:0] ack_at, input logic [7:0] cfg_at);
        int cnt = 0;
        logic [3:0] e;
        int b;
        pend_q.push_back(exp_pend);
        busy_q.push_back(exp_busy);
        {year, mon, dom, dow, mode, hour, min, sec} = t;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        while (busy && cnt < 40) begin
            hist[cnt % 16] = pend;
            tick   = (cnt < 8) ? tick_at[cnt] : 1'b0;
            ack    = (cnt < 8) ? ack_at[cnt] : 1'b0;
            cfg_we = (cnt < 8) ? cfg_at[cnt] : 1'b0;
            cnt++;
            @(negedge clk);
        end
        tick = 1'b0; ack = 1'b0; cfg_we = 1'b0;
        b = busy_q.pop_front();
        e = pend_q.pop_front();
        chk("busy_cycles", cnt, b);
        chk("scan_pending", pend, e);
    endtask

    initial begin
        logic [43:0] ta, ta1, tz, tbt, w5, w6;
        ta  = mk(15, 30, 12, 0, 0, 1, 1, 2023);
        ta1 = mk(16, 30, 12, 0, 0, 1, 1, 2023);
        tz  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbt = mk(45, 10, 8, 1, 3, 15, 6, 2024);
        w5  = mk(0, 5, 9, 0, 2, 3, 4, 2025);
        w6  = mk(0, 6, 9, 0, 2, 3, 4, 2025);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_pending", pend, 0);
        chk("rst_irq", irq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);

        write_cfg(2, 1'b1, ta, 8'hFF);
        {year, mon, dom, dow, mode, hour, min, sec} = ta;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midscan_rst_busy", busy, 0);
        @(negedge clk);
        chk("midscan_rst_pending", pend, 0);

        write_cfg(2, 1'b1, ta, 8'hFF);
        scan(ta, 4'b0100, 4, 8'h00, 8'h00, 8'h00);
        chk("pend_e0p2", hist[2], 4'b0000);
        chk("pend_e0p3", hist[3], 4'b0100);
        chk("irq_set", irq, 1);

        ack_slot(2);
        chk("ack_pending", pend, 0);
        chk("ack_irq", irq, 0);
        scan(ta1, 4'b0000, 4, 8'h00, 8'h00, 8'h00);
        scan(ta, 4'b0100, 4, 8'h00, 8'h00, 8'h00);
        ack_idx = 2'd2;
        scan(ta, 4'b0100, 4, 8'h00, 8'b0000_0100, 8'h00);
        ack_slot(2);

        scan(tz, 4'b0000, 8, 8'b0000_0010, 8'h00, 8'h00);
        chk("one_extra_ovf", ovf, 0);
        scan(tz, 4'b0000, 8, 8'b0000_1000, 8'h00, 8'h00);
        chk("last_edge_ovf", ovf, 0);
        scan(tz, 4'b0000, 8, 8'b0000_0110, 8'h00, 8'h00);
        chk("ovf_set", ovf, 1);
        scan(tz, 4'b0000, 4, 8'h00, 8'h00, 8'h00);
        chk("ovf_sticky", ovf, 1);

        write_cfg(1, 1'b1, tbt, 8'hFF);
        scan(tbt, 4'b0010, 4, 8'h00, 8'h00, 8'h00);
        write_cfg(1, 1'b0, tbt, 8'hFF);
        chk("cfg_clear_pending", pend, 0);
        write_cfg(1, 1'b1, tbt, 8'hFF);
        cfg_idx = 2'd1; cfg_en = 1'b0; cfg_time = tbt;
        scan(tbt, 4'b0000, 4, 8'h00, 8'h00, 8'b0000_0010);
        write_cfg(1, 1'b1, tbt, 8'hFF);
        cfg_idx = 2'd1; cfg_en = 1'b1; cfg_time = tz;
        scan(tbt, 4'b0010, 4, 8'h00, 8'h00, 8'b0000_0010);
        scan(tbt, 4'b0010, 4, 8'h00, 8'h00, 8'h00);
        write_cfg(1, 1'b0, tz, 8'hFF);
        chk("slot1_disabled", pend, 0);

        write_cfg(0, 1'b1, w5, 8'h01);
        scan(w5, 4'b0001, 4, 8'h00, 8'h00, 8'h00);
        ack_slot(0);
`ifdef RTC_ALARM_WILDCARD_EN
        scan(w6, 4'b0001, 4, 8'h00, 8'h00, 8'h00);
        ack_slot(0);
        write_cfg(0, 1'b1, w5, 8'h00);
        scan(tz, 4'b0001, 4, 8'h00, 8'h00, 8'h00);
        ack_slot(0);
`else
        scan(w6, 4'b0000, 4, 8'h00, 8'h00, 8'h00);
`endif
        chk("final_pending", pend, 0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ovf_cleared", ovf, 0);
        chk("busy_idle", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
